// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port owner: zero-fills x1..x31 after reset or clear, then arbitrates
// writebacks between the pipeline (priority) and the MDU, with a starvation guarantee.
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned XLEN         = 32,
  parameter int unsigned AW           = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear_req,
  input  logic            pipe_valid,
  input  logic [AW-1:0]   pipe_wa,
  input  logic [XLEN-1:0] pipe_wd,
  output logic            pipe_ready,
  input  logic            mdu_valid,
  input  logic [AW-1:0]   mdu_wa,
  input  logic [XLEN-1:0] mdu_wd,
  output logic            mdu_ready,
  output logic            rf_we,
  output logic [AW-1:0]   rf_wa,
  output logic [XLEN-1:0] rf_wd,
  output logic            init_busy
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] StarveMax = SW'(STARVE_LIMIT);
  localparam logic [AW-1:0] IdxFirst  = AW'(1);
  localparam logic [AW-1:0] IdxLast   = {AW{1'b1}};

  typedef enum logic {StInit, StRun} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          force_mdu;
  logic          gnt_pipe, gnt_mdu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StInit;
      idx_q    <= IdxFirst;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    starve_d   = starve_q;
    force_mdu  = 1'b0;
    gnt_pipe   = 1'b0;
    gnt_mdu    = 1'b0;
    pipe_ready = 1'b0;
    mdu_ready  = 1'b0;
    init_busy  = 1'b1;
    rf_we      = 1'b0;
    rf_wa      = '0;
    rf_wd      = '0;

    unique case (state_q)
      StInit: begin
        rf_we    = 1'b1;
        rf_wa    = idx_q;
        starve_d = '0;
        if (idx_q == IdxLast) begin
          state_d = StRun;
          idx_d   = IdxFirst;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      StRun: begin
        init_busy  = 1'b0;
        force_mdu  = (starve_q == StarveMax);
        pipe_ready = !force_mdu;
        mdu_ready  = force_mdu | !pipe_valid;
        // mdu_ready already encodes priority, so the two grants are exclusive
        gnt_mdu    = mdu_valid & mdu_ready;
        gnt_pipe   = pipe_valid & pipe_ready;
        if (gnt_mdu) begin
          rf_wa = mdu_wa;
          rf_wd = mdu_wd;
        end else if (gnt_pipe) begin
          rf_wa = pipe_wa;
          rf_wd = pipe_wd;
        end
        rf_we = (gnt_mdu | gnt_pipe) & (rf_wa != '0);

        if (gnt_mdu) begin
          starve_d = '0;
        end else if (mdu_valid && !mdu_ready && starve_q != StarveMax) begin
          starve_d = starve_q + SW'(1);
        end

        if (clear_req) begin
          state_d  = StInit;
          idx_d    = IdxFirst;
          starve_d = '0;
        end
      end
      default: begin
        state_d = StInit;
        idx_d   = IdxFirst;
      end
    endcase

    // Reset must silence the port immediately, not at the next edge
    if (!rst_n) begin
      rf_we      = 1'b0;
      pipe_ready = 1'b0;
      mdu_ready  = 1'b0;
      init_busy  = 1'b1;
    end
  end

  a_one_grant: assert property (@(posedge clk) disable iff (!rst_n) !(gnt_pipe && gnt_mdu));
  a_no_x0:     assert property (@(posedge clk) disable iff (!rst_n) rf_we |-> (rf_wa != '0));

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Owns the single write port of the 32x32 register file and shares it between two writeback requesters: the in-order pipeline writeback stage and the multi-cycle MDU (mul/div unit).
After reset, and on a software clear request, it first sequences a zero-fill of x1..x31.
The pipeline has priority. A starvation counter guarantees the MDU a slot within STARVE_LIMIT contended cycles.
The block sits between the WB stage / MDU and the register file write port (we/wa/wd).

Parameters:
STARVE_LIMIT, 4, consecutive blocked MDU cycles before the MDU is forced a grant (>=1)
XLEN, 32, data width
AW, 5, register address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
clear_req  in  1  pulse; restart the zero-fill sequence
pipe_valid  in  1  pipeline writeback request
pipe_wa  in  AW  pipeline destination register
pipe_wd  in  XLEN  pipeline write data
pipe_ready  out  1  pipeline request accepted this cycle when high with pipe_valid
mdu_valid  in  1  MDU writeback request; held until accepted
mdu_wa  in  AW  MDU destination register
mdu_wd  in  XLEN  MDU write data
mdu_ready  out  1  MDU handshake
rf_we  out  1  register file write enable
rf_wa  out  AW  register file write address
rf_wd  out  XLEN  register file write data
init_busy  out  1  zero-fill in progress; the pipeline must not issue

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n). All flops clear on rst_n low, independent of clk.
- State: INIT/RUN, idx[AW-1:0], starve[$clog2(STARVE_LIMIT+1)-1:0].
- Reset values:
  - state=INIT, idx=1, starve=0.
  - While rst_n is low: rf_we=0, pipe_ready=0, mdu_ready=0, init_busy=1.
- Write-port outputs are combinational from state and requests (zero-latency grant). The register file commits on the same clk edge.
- INIT:
  - rf_we=1, rf_wa=idx, rf_wd=0.
  - pipe_ready=0, mdu_ready=0, init_busy=1.
  - idx increments each cycle.
  - In the cycle with idx==31, next state is RUN and idx reloads to 1.
  - Exactly 31 write cycles (x1..x31). x0 is never written.
  - clear_req during INIT is ignored; the sequence is not restarted.
- RUN: init_busy=0, and:
  - force = (starve==STARVE_LIMIT).
  - pipe_ready = !force.
  - mdu_ready = force | !pipe_valid.
  - Grant priority: force&mdu_valid -> MDU; else pipe_valid -> pipe; else mdu_valid -> MDU; else idle with rf_we=0.
  - rf_wa/rf_wd are muxed from the granted requester. When idle, they are 0.
  - rf_we = grant & (granted wa != 0). A request to x0 still completes its handshake but produces no write.
- starve counter (RUN only):
  - On mdu_valid & !mdu_ready: +1, saturating at STARVE_LIMIT.
  - On an MDU handshake: cleared to 0.
  - Otherwise: holds.
  - Held at 0 in INIT.
- MDU protocol: once mdu_valid is asserted it stays high, with wa/wd stable, until the handshake. Deasserting early is a protocol violation; behaviour is undefined.
- The pipeline may drop pipe_valid at any time. When pipe_ready=0 it must hold the request (stall).
- clear_req in RUN:
  - Current-cycle handshakes and writes complete normally.
  - Next state is INIT with idx=1 and starve=0.
  - A write granted in the same cycle is subsequently overwritten to 0 by the fill.
- Asserting rst_n low mid-INIT or mid-RUN aborts immediately. After release, the fill restarts from x1.
- Same-address writes from both requesters are never simultaneous (one grant per cycle). Ordering equals grant order.
- Only one register-file write per cycle, ever.

Test Plan:
- Release reset, hold all requests low -> rf_we=1 for 31 cycles, rf_wa=1..31, rf_wd=0, init_busy=1. Cycle 32: init_busy=0, rf_we=0. The register file reads 0 for all 32 addresses.
- RUN, pipe_valid=1 with wa=5/wd=0xDEADBEEF, mdu_valid=0 -> same cycle: pipe_ready=1, rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF. rd1 with ra1=5 reads 0xDEADBEEF next cycle.
- RUN, pipe_valid held 1 for 10 cycles, mdu_valid=1 with wa=7/wd=0x1234 from cycle 0:
  - Cycles 0-3: pipe granted, starve counts 1..4.
  - Cycle 4: pipe_ready=0, mdu_ready=1, rf_wa=7, rf_wd=0x1234, starve->0.
  - Cycle 5: pipe resumes.
- RUN, pipe_valid=0, mdu_valid=1 with wa=0/wd=0xFFFFFFFF -> mdu_ready=1, rf_we=0. x0 still reads 0 and starve stays 0.
- RUN, clear_req=1 with pipe_valid=1 (wa=9, wd=0xA5A5A5A5) in the same cycle:
  - That cycle: write of 9 <- 0xA5A5A5A5 occurs.
  - Next 31 cycles: INIT, with x9 zeroed at fill step 9, and pipe_ready=0 throughout.
- Drop rst_n at fill step idx=12 -> outputs go to reset values asynchronously. After release, the fill restarts at rf_wa=1 and takes 31 full cycles.
